lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  Load/store initiator for the EX->MEM boundary. Accepts one access per handshake (ctrl, addr, store data)
//  and drives a 64-bit little-endian byte-addressed memory bus, one outstanding beat at a time.
//  Generates lane-aligned write data and byte strobes, and splits line-crossing (addr[2:0]+size>8) accesses
//  into two beats. Sign/zero-extends load data and returns rd/ctrl/data to writeback.
// PARAMETERS
//  XLEN    64  register/data width (RV64GC_ISA); bus data width = 64, strobe width = 8
//  ADDR_W  64  byte address width
// PORTS
//  clk_sys_i        in   1       system clock
//  rst_sys_i        in   1       reset, synchronous, active-high
//  req_valid_i      in   1       access request valid
//  req_ready_o      out  1       request accepted when valid&ready
//  req_ctrl_i       in   8       [6:3] class (`CTRL_ACCESS_I load / `CTRL_ACCESS_S store), [2:0] funct3
//  req_rd_i         in   5       load destination register
//  req_addr_i       in   ADDR_W  byte address
//  req_wdata_i      in   XLEN    store data, right-justified
//  bus_req_valid_o  out  1       bus beat valid; held until bus_req_ready_i
//  bus_req_ready_i  in   1       bus accepts beat
//  bus_req_we_o     out  1       1 = write beat
//  bus_req_addr_o   out  ADDR_W  8-byte-aligned beat address ([2:0]=0)
//  bus_req_wstrb_o  out  8       byte enables (write beats; 0 on reads)
//  bus_req_wdata_o  out  64      lane-aligned write data
//  bus_rsp_valid_i  in   1       beat response (read data or write ack), >=1 cycle after accept
//  bus_rsp_rdata_i  in   64      read data, full aligned doubleword
//  rsp_valid_o      out  1       one-cycle completion pulse
//  rsp_rd_o         out  5       rd of completed access
//  rsp_ctrl_o       out  8       ctrl of completed access
//  rsp_data_o       out  XLEN    extended load data; 0 for stores
//  rsp_err_o        out  1       illegal funct3 for class; qualified by rsp_valid_o
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1; captured request cleared.
//  Size = 1<<funct3[1:0]; off = addr[2:0]. Loads LB/LH/LW/LD/LBU/LHU/LWU = 0..6; stores SB/SH/SW/SD = 0..3.
//  Illegal: load funct3=7, store funct3[2]=1 -> no bus traffic, rsp_valid_o next cycle, rsp_err_o=1, data 0.
//  Non-access class: accepted and dropped; no bus traffic, no rsp_valid_o.
//  FSM: IDLE -accept-> REQ0 -bus_req_ready-> RSP0 -bus_rsp_valid-> (split ? REQ1 : DONE);
//       REQ1 -ready-> RSP1 -rsp_valid-> DONE; DONE (rsp_valid_o=1, 1 cycle) -> IDLE.
//  req_ready_o = (state==IDLE). Request fields registered at accept; inputs ignored otherwise.
//  bus_req_valid_o high in REQ0/REQ1 only; addr/we/wstrb/wdata stable while valid&!ready.
//  Beat0 addr = {addr[63:3],3'b0}; beat1 addr = beat0 addr + 8 (wraps mod 2^ADDR_W).
//  Store lanes: W128 = zext(wdata) << (off*8); S16 = ((1<<size)-1) << off.
//    beat0 wdata/wstrb = W128[63:0]/S16[7:0]; beat1 = W128[127:64]/S16[15:8].
//  Load: beat0 rdata latched in RSP0; beat1 rdata used directly in RSP1. R128 = {beat1,beat0} >> (off*8);
//    low size bytes extended per funct3 (sign for LB/LH/LW, zero for LBU/LHU/LWU, none LD).
//  Latency (no stall, rsp 1 cycle after accept): single beat accept T -> bus valid T+1 -> rsp T+2 ->
//    rsp_valid_o T+3. Split adds 2 cycles.
//  bus_rsp_valid_i outside RSP0/RSP1 ignored (no effect, no error).
//  Reset mid-operation: FSM to IDLE next edge, bus_req_valid_o drops, no rsp_valid_o; late responses ignored.
//  Back-to-back: a new request is accepted the cycle after DONE (IDLE); no overlap of accesses.
// STRUCTURE
//  Shared header (QianTang_header.v): `CTRL_ACCESS_I/S, LB..LWU/SB..SD codes (existing),
//    plus new `LSU_ST_IDLE/REQ0/RSP0/REQ1/RSP1/DONE state codes (3-bit).
//  Sub-module lsu_load_extend: combinational (R128[63:0], funct3) -> XLEN extended result.
//  Top: FSM, request capture, lane/strobe generation, beat0 data holding register.
// TESTING
//  LD addr 0x1000, rdata 0x8877665544332211 -> one read beat @0x1000, rsp_data 0x8877665544332211, rd echoed.
//  LB addr 0x1003, rdata 0x0000_0000_F000_0000 -> rsp_data 0xFFFFFFFFFFFFFFF0; LBU same -> 0xF0.
//  SW addr 0x2006, wdata 0xAABBCCDD -> beat0 @0x2000 wstrb 0xC0 wdata[63:48]=0xCCDD;
//    beat1 @0x2008 wstrb 0x03 wdata[15:0]=0xAABB; rsp after second ack.
//  LW addr 0x3FFE, beat0 rdata[63:48]=0x2211, beat1 rdata[15:0]=0x8044 -> rsp_data 0xFFFFFFFF80442211.
//  bus_req_ready_i low 5 cycles in REQ0 -> bus signals stable, req_ready_o=0; store funct3=4 -> rsp_err_o=1, no beat.
//  Assert rst_sys_i in RSP0, then drive bus_rsp_valid_i -> no rsp_valid_o, req_ready_o=1 after reset.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings for the load/store bus master: access classes, funct3 codes and FSM states.
package lsu_bus_master_pkg;

  localparam logic [3:0] CTRL_ACCESS_I = 4'h1;
  localparam logic [3:0] CTRL_ACCESS_S = 4'h2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SD  = 3'd3;

  typedef enum logic [2:0] {
    LSU_ST_IDLE = 3'd0,
    LSU_ST_REQ0 = 3'd1,
    LSU_ST_RSP0 = 3'd2,
    LSU_ST_REQ1 = 3'd3,
    LSU_ST_RSP1 = 3'd4,
    LSU_ST_DONE = 3'd5
  } lsu_state_e;

  function automatic logic is_illegal(input logic [3:0] cls, input logic [2:0] funct3);
    return ((cls == CTRL_ACCESS_I) && (funct3 == 3'd7)) ||
           ((cls == CTRL_ACCESS_S) && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the right-justified load bytes according to funct3.
module lsu_load_extend
  import lsu_bus_master_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     raw,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(raw[7:0]));
      F3_LH:   result = XLEN'($signed(raw[15:0]));
      F3_LW:   result = XLEN'($signed(raw[31:0]));
      F3_LD:   result = XLEN'(raw);
      F3_LBU:  result = XLEN'(raw[7:0]);
      F3_LHU:  result = XLEN'(raw[15:0]);
      F3_LWU:  result = XLEN'(raw[31:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one access at a time onto a 64-bit little-endian bus, splitting
// line-crossing accesses into two beats and returning extended load data to writeback.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [7:0]        req_ctrl_i,
  input  logic [4:0]        req_rd_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic              bus_req_we_o,
  output logic [ADDR_W-1:0] bus_req_addr_o,
  output logic [7:0]        bus_req_wstrb_o,
  output logic [63:0]       bus_req_wdata_o,
  input  logic              bus_rsp_valid_i,
  input  logic [63:0]       bus_rsp_rdata_i,
  output logic              rsp_valid_o,
  output logic [4:0]        rsp_rd_o,
  output logic [7:0]        rsp_ctrl_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  lsu_state_e        state;
  logic [7:0]        ctrl_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [63:0]       beat0_q;

  logic              is_load_q, is_store_q, split_q, beat1_sel;
  logic [3:0]        size_q;
  logic [2:0]        off_q;
  logic [127:0]      w128;
  logic [15:0]       s16;
  logic [63:0]       rd_lo, rd_hi, ext_raw;
  logic [XLEN-1:0]   ext_data;

  assign is_load_q  = (ctrl_q[6:3] == CTRL_ACCESS_I);
  assign is_store_q = (ctrl_q[6:3] == CTRL_ACCESS_S);
  assign size_q     = 4'd1 << ctrl_q[1:0];
  assign off_q      = addr_q[2:0];
  assign split_q    = ({1'b0, off_q} + size_q) > 4'd8;
  assign beat1_sel  = (state == LSU_ST_REQ1) || (state == LSU_ST_RSP1);

  // Store data and strobes shifted into byte lanes across a 16-byte window.
  assign w128 = 128'(wdata_q[63:0]) << {off_q, 3'b000};
  assign s16  = ((16'd1 << size_q) - 16'd1) << off_q;

  assign req_ready_o     = (state == LSU_ST_IDLE);
  assign bus_req_we_o    = is_store_q;
  assign bus_req_addr_o  = {addr_q[ADDR_W-1:3], 3'b000} + ADDR_W'({beat1_sel, 3'b000});
  assign bus_req_wstrb_o = !is_store_q ? 8'h00 : (beat1_sel ? s16[15:8] : s16[7:0]);
  assign bus_req_wdata_o = beat1_sel ? w128[127:64] : w128[63:0];
  assign rsp_rd_o        = rd_q;
  assign rsp_ctrl_o      = ctrl_q;

  // The second beat's data is used straight off the bus; the first comes from the holding register.
  assign rd_lo   = (state == LSU_ST_RSP1) ? beat0_q : bus_rsp_rdata_i;
  assign rd_hi   = (state == LSU_ST_RSP1) ? bus_rsp_rdata_i : 64'h0;
  assign ext_raw = 64'({rd_hi, rd_lo} >> {off_q, 3'b000});

  lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (ext_raw),
    .funct3 (ctrl_q[2:0]),
    .result (ext_data)
  );

  // NOTE: all state here is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state           <= LSU_ST_IDLE;
      ctrl_q          <= '0;
      rd_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      beat0_q         <= '0;
      bus_req_valid_o <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_err_o       <= 1'b0;
      rsp_data_o      <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      case (state)
        LSU_ST_IDLE: if (req_valid_i) begin
          ctrl_q  <= req_ctrl_i;
          rd_q    <= req_rd_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          if (is_illegal(req_ctrl_i[6:3], req_ctrl_i[2:0])) begin
            state       <= LSU_ST_DONE;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_data_o  <= '0;
          end else if ((req_ctrl_i[6:3] == CTRL_ACCESS_I) ||
                       (req_ctrl_i[6:3] == CTRL_ACCESS_S)) begin
            state           <= LSU_ST_REQ0;
            bus_req_valid_o <= 1'b1;
          end
        end
        LSU_ST_REQ0: if (bus_req_ready_i) begin
          state           <= LSU_ST_RSP0;
          bus_req_valid_o <= 1'b0;
        end
        LSU_ST_RSP0: if (bus_rsp_valid_i) begin
          beat0_q <= bus_rsp_rdata_i;
          if (split_q) begin
            state           <= LSU_ST_REQ1;
            bus_req_valid_o <= 1'b1;
          end else begin
            state       <= LSU_ST_DONE;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= is_load_q ? ext_data : '0;
          end
        end
        LSU_ST_REQ1: if (bus_req_ready_i) begin
          state           <= LSU_ST_RSP1;
          bus_req_valid_o <= 1'b0;
        end
        LSU_ST_RSP1: if (bus_rsp_valid_i) begin
          state       <= LSU_ST_DONE;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= is_load_q ? ext_data : '0;
        end
        LSU_ST_DONE: state <= LSU_ST_IDLE;
        default:     state <= LSU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: directed accesses, a bus slave model and a decoupled monitor.
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_ctrl_i;
  logic [4:0]  req_rd_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic        bus_req_we_o;
  logic [63:0] bus_req_addr_o;
  logic [7:0]  bus_req_wstrb_o;
  logic [63:0] bus_req_wdata_o;
  logic        bus_rsp_valid_i;
  logic [63:0] bus_rsp_rdata_i;
  logic        rsp_valid_o;
  logic [4:0]  rsp_rd_o;
  logic [7:0]  rsp_ctrl_o;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;

  lsu_bus_master dut (
    .clk_sys_i       (clk_sys_i),
    .rst_sys_i       (rst_sys_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_ctrl_i      (req_ctrl_i),
    .req_rd_i        (req_rd_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .bus_req_valid_o (bus_req_valid_o),
    .bus_req_ready_i (bus_req_ready_i),
    .bus_req_we_o    (bus_req_we_o),
    .bus_req_addr_o  (bus_req_addr_o),
    .bus_req_wstrb_o (bus_req_wstrb_o),
    .bus_req_wdata_o (bus_req_wdata_o),
    .bus_rsp_valid_i (bus_rsp_valid_i),
    .bus_rsp_rdata_i (bus_rsp_rdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rd_o        (rsp_rd_o),
    .rsp_ctrl_o      (rsp_ctrl_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_err_o       (rsp_err_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  beat_t       exp_beat_q[$];
  rsp_t        exp_rsp_q[$];
  logic [63:0] rdata_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        stall_on = 1'b0;
  logic        hold_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mk_ctrl(input logic [3:0] cls, input logic [2:0] f3);
    return {1'b0, cls, f3};
  endfunction

  task automatic exp_beat(input logic [63:0] a, input logic we, input logic [7:0] s, input logic [63:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.wstrb = s; b.wdata = d;
    exp_beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic [4:0] rd, input logic [7:0] ctrl, input logic [63:0] d, input logic err);
    rsp_t r;
    r.rd = rd; r.ctrl = ctrl; r.data = d; r.err = err;
    exp_rsp_q.push_back(r);
  endtask

  // Bus slave: ready unless stalled, answers each accepted beat one cycle later unless held.
  initial begin
    logic        acc, acc_we, pend;
    logic [63:0] pend_data;
    bus_req_ready_i = 1'b1;
    bus_rsp_valid_i = 1'b0;
    bus_rsp_rdata_i = '0;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk_sys_i);
      acc    = bus_req_valid_o && bus_req_ready_i && !rst_sys_i;
      acc_we = bus_req_we_o;
      @(posedge clk_sys_i);
      #1;
      if (acc) begin
        pend = 1'b1;
        pend_data = (!acc_we && rdata_q.size() > 0) ? rdata_q.pop_front() : 64'h0;
      end
      if (pend && !hold_rsp) begin
        bus_rsp_valid_i = 1'b1;
        bus_rsp_rdata_i = pend_data;
        pend = 1'b0;
      end else begin
        bus_rsp_valid_i = 1'b0;
      end
      bus_req_ready_i = !stall_on;
    end
  end

  // Monitor: compares every accepted beat and every completion against the scoreboard.
  always @(negedge clk_sys_i) begin
    if (!rst_sys_i) begin
      if (bus_req_valid_o && bus_req_ready_i) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          beat_t b;
          b = exp_beat_q.pop_front();
          check("beat_addr", bus_req_addr_o, b.addr);
          check("beat_we", 64'(bus_req_we_o), 64'(b.we));
          check("beat_wstrb", 64'(bus_req_wstrb_o), 64'(b.wstrb));
          if (b.we) check("beat_wdata", bus_req_wdata_o, b.wdata);
        end
      end
      if (rsp_valid_o) begin
        if (exp_rsp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else begin
          rsp_t r;
          r = exp_rsp_q.pop_front();
          check("rsp_rd", 64'(rsp_rd_o), 64'(r.rd));
          check("rsp_ctrl", 64'(rsp_ctrl_o), 64'(r.ctrl));
          check("rsp_data", rsp_data_o, r.data);
          check("rsp_err", 64'(rsp_err_o), 64'(r.err));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys_i);
    #1;
  endtask

  task automatic issue(input logic [7:0] ctrl, input logic [4:0] rd, input logic [63:0] addr,
                       input logic [63:0] wdata);
    int n = 0;
    while (!req_ready_o && n < 200) begin
      @(posedge clk_sys_i); #1; n++;
    end
    if (n >= 200) check("issue_timeout", 64'd1, 64'd0);
    req_valid_i = 1'b1;
    req_ctrl_i  = ctrl;
    req_rd_i    = rd;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(posedge clk_sys_i); #1;
    req_valid_i = 1'b0;
    req_ctrl_i  = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_beat_q.size() != 0 || exp_rsp_q.size() != 0) && n < 200) begin
      @(posedge clk_sys_i); #1; n++;
    end
    if (n >= 200) check("drain_timeout", 64'd1, 64'd0);
    tick(2);
  endtask

  initial begin
    logic [7:0] c;
    int         n;
    rst_sys_i = 1'b1;
    req_valid_i = 1'b0;
    req_ctrl_i = '0;
    req_rd_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    tick(3);
    rst_sys_i = 1'b0;
    @(negedge clk_sys_i);
    check("reset_req_ready", 64'(req_ready_o), 64'd1);
    check("reset_bus_valid", 64'(bus_req_valid_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_rsp_data", rsp_data_o, 64'd0);
    check("reset_bus_addr", bus_req_addr_o, 64'd0);
    check("reset_wstrb", 64'(bus_req_wstrb_o), 64'd0);
    tick(1);

    c = mk_ctrl(CTRL_ACCESS_I, F3_LD);
    rdata_q.push_back(64'h8877665544332211);
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd5, c, 64'h8877665544332211, 1'b0);
    issue(c, 5'd5, 64'h1000, 64'h0);
    drain();

    c = mk_ctrl(CTRL_ACCESS_I, F3_LB);
    rdata_q.push_back(64'h00000000F0000000);
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd6, c, 64'hFFFFFFFFFFFFFFF0, 1'b0);
    issue(c, 5'd6, 64'h1003, 64'h0);
    drain();

    c = mk_ctrl(CTRL_ACCESS_I, F3_LBU);
    rdata_q.push_back(64'h00000000F0000000);
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd7, c, 64'h00000000000000F0, 1'b0);
    issue(c, 5'd7, 64'h1003, 64'h0);
    drain();

    c = mk_ctrl(CTRL_ACCESS_S, F3_SW);
    exp_beat(64'h2000, 1'b1, 8'hC0, 64'hCCDD000000000000);
    exp_beat(64'h2008, 1'b1, 8'h03, 64'h000000000000AABB);
    exp_rsp(5'd8, c, 64'h0, 1'b0);
    issue(c, 5'd8, 64'h2006, 64'h00000000AABBCCDD);
    drain();

    c = mk_ctrl(CTRL_ACCESS_I, F3_LW);
    rdata_q.push_back(64'h2211000000000000);
    rdata_q.push_back(64'h0000000000008044);
    exp_beat(64'h3FF8, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h4000, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd9, c, 64'hFFFFFFFF80442211, 1'b0);
    issue(c, 5'd9, 64'h3FFE, 64'h0);
    drain();

    c = mk_ctrl(CTRL_ACCESS_I, F3_LH);
    rdata_q.push_back(64'hAB00000000000000);
    rdata_q.push_back(64'h0000000000000012);
    exp_beat(64'h5000, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h5008, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd10, c, 64'h00000000000012AB, 1'b0);
    issue(c, 5'd10, 64'h5007, 64'h0);
    drain();

    c = mk_ctrl(CTRL_ACCESS_S, F3_SB);
    exp_beat(64'h6000, 1'b1, 8'h20, 64'h0001FF0000000000);
    exp_rsp(5'd11, c, 64'h0, 1'b0);
    issue(c, 5'd11, 64'h6005, 64'h00000000000001FF);
    drain();

    // Line-crossing doubleword at the top of the address space wraps to 0.
    c = mk_ctrl(CTRL_ACCESS_I, F3_LD);
    rdata_q.push_back(64'h0706050403020100);
    rdata_q.push_back(64'h0000000000000008);
    exp_beat(64'hFFFFFFFFFFFFFFF8, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h0000000000000000, 1'b0, 8'h00, 64'h0);
    exp_rsp(5'd12, c, 64'h0807060504030201, 1'b0);
    issue(c, 5'd12, 64'hFFFFFFFFFFFFFFF9, 64'h0);
    drain();

    stall_on = 1'b1;
    tick(2);
    c = mk_ctrl(CTRL_ACCESS_S, F3_SD);
    exp_beat(64'h4000, 1'b1, 8'hFF, 64'h0123456789ABCDEF);
    exp_rsp(5'd13, c, 64'h0, 1'b0);
    issue(c, 5'd13, 64'h4000, 64'h0123456789ABCDEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys_i);
      check("stall_valid", 64'(bus_req_valid_o), 64'd1);
      check("stall_addr", bus_req_addr_o, 64'h4000);
      check("stall_wstrb", 64'(bus_req_wstrb_o), 64'hFF);
      check("stall_wdata", bus_req_wdata_o, 64'h0123456789ABCDEF);
      check("stall_req_ready", 64'(req_ready_o), 64'd0);
    end
    stall_on = 1'b0;
    drain();

    c = mk_ctrl(CTRL_ACCESS_S, 3'd4);
    exp_rsp(5'd14, c, 64'h0, 1'b1);
    issue(c, 5'd14, 64'h7000, 64'hFFFF);
    drain();

    c = mk_ctrl(CTRL_ACCESS_I, 3'd7);
    exp_rsp(5'd15, c, 64'h0, 1'b1);
    issue(c, 5'd15, 64'h7008, 64'h0);
    drain();

    // A non-access class is swallowed without bus traffic or completion.
    issue(mk_ctrl(4'h0, F3_LD), 5'd16, 64'h7010, 64'h0);
    tick(6);
    check("drop_req_ready", 64'(req_ready_o), 64'd1);

    // Reset while waiting for a read response; the late response must be ignored.
    hold_rsp = 1'b1;
    c = mk_ctrl(CTRL_ACCESS_I, F3_LD);
    rdata_q.push_back(64'hDEADBEEFDEADBEEF);
    exp_beat(64'h8000, 1'b0, 8'h00, 64'h0);
    issue(c, 5'd17, 64'h8000, 64'h0);
    n = 0;
    do begin
      @(negedge clk_sys_i); n++;
    end while ((bus_req_valid_o || req_ready_o) && n < 50);
    check("reached_rsp0", 64'(n < 50), 64'd1);
    @(posedge clk_sys_i); #1;
    rst_sys_i = 1'b1;
    tick(2);
    rst_sys_i = 1'b0;
    hold_rsp = 1'b0;
    tick(6);
    check("post_reset_req_ready", 64'(req_ready_o), 64'd1);
    check("post_reset_bus_valid", 64'(bus_req_valid_o), 64'd0);

    check("beat_queue_empty", 64'(exp_beat_q.size()), 64'd0);
    check("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
